// File: rtl/snif_multi.sv
// Multi-channel bus write sniffer. Each channel compares the bus address with
// its own match/mask pair and produces a detect pulse, sticky flag, counter and data capture.

module snif_chan #(
  parameter int                    ADR_WIDTH = 6,
  parameter int                    DAT_WIDTH = 8,
  parameter int                    CNT_WIDTH = 8,
  parameter logic [ADR_WIDTH-1:0]  RST_ADR   = '0,
  parameter logic                  RST_EN    = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [ADR_WIDTH-1:0] adr_i,
  input  logic [DAT_WIDTH-1:0] dat_i,
  input  logic                 we_i,
  input  logic                 cfg_we_i,
  input  logic [ADR_WIDTH-1:0] cfg_adr_i,
  input  logic [ADR_WIDTH-1:0] cfg_msk_i,
  input  logic                 cfg_en_i,
  input  logic                 clr_i,
  output logic                 detect_o,
  output logic                 flag_o,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic [DAT_WIDTH-1:0] dat_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [ADR_WIDTH-1:0] adr_q, adr_d;
  logic [ADR_WIDTH-1:0] msk_q, msk_d;
  logic                 en_q, en_d;
  logic                 detect_q, detect_d;
  logic                 flag_q, flag_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DAT_WIDTH-1:0] dat_q, dat_d;
  logic                 hit;

  // Match uses the config registered before this edge, so a same-cycle
  // config write never affects the current bus write.
  assign hit = en_q & we_i & (((adr_i ^ adr_q) & msk_q) == '0);

  always_comb begin
    adr_d    = adr_q;
    msk_d    = msk_q;
    en_d     = en_q;
    detect_d = hit;
    flag_d   = hit | (flag_q & ~clr_i);
    cnt_d    = cnt_q;
    dat_d    = dat_q;
    if (cfg_we_i) begin
      adr_d = cfg_adr_i;
      msk_d = cfg_msk_i;
      en_d  = cfg_en_i;
    end
    // Clear restarts the count; a coincident hit counts as the first one.
    if (clr_i)
      cnt_d = hit ? CNT_WIDTH'(1) : '0;
    else if (hit && cnt_q != CNT_MAX)
      cnt_d = cnt_q + CNT_WIDTH'(1);
    if (hit)
      dat_d = dat_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      adr_q    <= RST_ADR;
      msk_q    <= '1;
      en_q     <= RST_EN;
      detect_q <= 1'b0;
      flag_q   <= 1'b0;
      cnt_q    <= '0;
      dat_q    <= '0;
    end else begin
      adr_q    <= adr_d;
      msk_q    <= msk_d;
      en_q     <= en_d;
      detect_q <= detect_d;
      flag_q   <= flag_d;
      cnt_q    <= cnt_d;
      dat_q    <= dat_d;
    end
  end

  assign detect_o = detect_q;
  assign flag_o   = flag_q;
  assign cnt_o    = cnt_q;
  assign dat_o    = dat_q;

endmodule

module snif_multi #(
  parameter int ADR_WIDTH = 6,
  parameter int DAT_WIDTH = 8,
  parameter int NCH       = 4,
  parameter int CNT_WIDTH = 8,
  parameter int SEL_WIDTH = (NCH > 1 ? $clog2(NCH) : 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [ADR_WIDTH-1:0]     adr_i,
  input  logic [DAT_WIDTH-1:0]     dat_i,
  input  logic                     we_i,
  input  logic                     cfg_we_i,
  input  logic [SEL_WIDTH-1:0]     cfg_sel_i,
  input  logic [ADR_WIDTH-1:0]     cfg_adr_i,
  input  logic [ADR_WIDTH-1:0]     cfg_msk_i,
  input  logic                     cfg_en_i,
  input  logic [NCH-1:0]           clr_i,
  output logic [NCH-1:0]           detect_o,
  output logic [NCH-1:0]           flag_o,
  output logic                     irq_o,
  output logic [NCH*CNT_WIDTH-1:0] cnt_o,
  output logic [NCH*DAT_WIDTH-1:0] dat_o
);

  logic [NCH-1:0]                cfg_hit;
  logic [NCH-1:0]                detect_w;
  logic [NCH-1:0]                flag_w;
  logic [NCH-1:0][CNT_WIDTH-1:0] cnt_w;
  logic [NCH-1:0][DAT_WIDTH-1:0] dat_w;
  logic                          irq_q, irq_d;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    // Out-of-range selects match no channel, so such writes are dropped.
    assign cfg_hit[c] = cfg_we_i & (cfg_sel_i == SEL_WIDTH'(c));

    snif_chan #(
      .ADR_WIDTH (ADR_WIDTH),
      .DAT_WIDTH (DAT_WIDTH),
      .CNT_WIDTH (CNT_WIDTH),
      .RST_ADR   ((c == 0) ? {ADR_WIDTH{1'b1}} : {ADR_WIDTH{1'b0}}),
      .RST_EN    (c == 0)
    ) u_chan (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .adr_i     (adr_i),
      .dat_i     (dat_i),
      .we_i      (we_i),
      .cfg_we_i  (cfg_hit[c]),
      .cfg_adr_i (cfg_adr_i),
      .cfg_msk_i (cfg_msk_i),
      .cfg_en_i  (cfg_en_i),
      .clr_i     (clr_i[c]),
      .detect_o  (detect_w[c]),
      .flag_o    (flag_w[c]),
      .cnt_o     (cnt_w[c]),
      .dat_o     (dat_w[c])
    );
  end

  always_comb begin
    irq_d = |flag_w;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_q <= 1'b0;
    else         irq_q <= irq_d;
  end

  assign detect_o = detect_w;
  assign flag_o   = flag_w;
  assign irq_o    = irq_q;
  assign cnt_o    = cnt_w;
  assign dat_o    = dat_w;

endmodule

// File: tb/tb_snif_multi.sv
// Directed bench for snif_multi: expected detect vectors are queued when a bus
// cycle is driven and compared once the registered result appears.

module tb_snif_multi;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [5:0]  adr_i;
  logic [7:0]  dat_i;
  logic        we_i;
  logic        cfg_we_i, cfg_we3;
  logic [1:0]  cfg_sel_i;
  logic [5:0]  cfg_adr_i, cfg_msk_i;
  logic        cfg_en_i;
  logic [3:0]  clr_i;
  logic [3:0]  detect_o, flag_o;
  logic        irq_o;
  logic [31:0] cnt_o, dat_o;
  logic [2:0]  detect3, flag3;
  logic        irq3;
  logic [23:0] cnt3, dat3;

  int vec = 0;
  int errs = 0;

  typedef struct {
    string      tag;
    logic [3:0] det;
  } sb_t;
  sb_t sb[$];

  always #5 clk_i = ~clk_i;

  snif_multi dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .adr_i(adr_i), .dat_i(dat_i), .we_i(we_i),
    .cfg_we_i(cfg_we_i), .cfg_sel_i(cfg_sel_i), .cfg_adr_i(cfg_adr_i),
    .cfg_msk_i(cfg_msk_i), .cfg_en_i(cfg_en_i), .clr_i(clr_i),
    .detect_o(detect_o), .flag_o(flag_o), .irq_o(irq_o), .cnt_o(cnt_o), .dat_o(dat_o)
  );

  // Three channels leave select value 3 out of range on a 2-bit select.
  snif_multi #(.NCH(3)) dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .adr_i(adr_i), .dat_i(dat_i), .we_i(we_i),
    .cfg_we_i(cfg_we3), .cfg_sel_i(cfg_sel_i), .cfg_adr_i(cfg_adr_i),
    .cfg_msk_i(cfg_msk_i), .cfg_en_i(cfg_en_i), .clr_i(clr_i[2:0]),
    .detect_o(detect3), .flag_o(flag3), .irq_o(irq3), .cnt_o(cnt3), .dat_o(dat3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One bus cycle: queue the expected detect vector, clock, then compare.
  task automatic bus(input string tag, input logic [5:0] a, input logic [7:0] d,
                     input logic w, input logic [3:0] exp_det);
    sb_t e;
    adr_i = a;
    dat_i = d;
    we_i  = w;
    sb.push_back('{tag, exp_det});
    tick();
    e = sb.pop_front();
    chk(e.tag, detect_o, e.det);
    we_i      = 1'b0;
    cfg_we_i  = 1'b0;
    cfg_we3   = 1'b0;
    clr_i     = '0;
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [5:0] a, input logic [5:0] m,
                     input logic en);
    cfg_sel_i = sel;
    cfg_adr_i = a;
    cfg_msk_i = m;
    cfg_en_i  = en;
    cfg_we_i  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 1'b0;
    adr_i = '0; dat_i = '0; we_i = 1'b0;
    cfg_we_i = 1'b0; cfg_we3 = 1'b0; cfg_sel_i = '0;
    cfg_adr_i = '0; cfg_msk_i = '0; cfg_en_i = 1'b0; clr_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_detect", detect_o, 4'h0);
    chk("rst_irq",    irq_o,    1'b0);
    chk("rst_cnt",    cnt_o,    32'h0);
    rst_ni = 1'b1;
    tick();

    // 1: only channel 0 watches the top address after reset
    for (int a = 0; a < 64; a++) bus("t1_idle", 6'(a), 8'h00, 1'b0, 4'h0);
    for (int a = 0; a < 63; a++) bus("t1_miss", 6'(a), 8'h00, 1'b1, 4'h0);
    chk("t1_flag_none", flag_o, 4'h0);
    bus("t1_hit63", 6'd63, 8'h11, 1'b1, 4'b0001);
    chk("t1_flag0", flag_o, 4'b0001);
    chk("t1_cnt0",  cnt_o[7:0], 8'd1);
    chk("t1_irq_lag", irq_o, 1'b0);
    bus("t1_pulse_end", 6'd0, 8'h00, 1'b0, 4'h0);
    chk("t1_irq", irq_o, 1'b1);

    // 2: masked match on channel 1
    cfg(2'd1, 6'h10, 6'h30, 1'b1);
    bus("t2_cfg", 6'd0, 8'h00, 1'b0, 4'h0);
    bus("t2_hit1A", 6'h1A, 8'hA5, 1'b1, 4'b0010);
    chk("t2_dat1", dat_o[15:8], 8'hA5);
    chk("t2_cnt1", cnt_o[15:8], 8'd1);
    bus("t2_miss2A", 6'h2A, 8'h5A, 1'b1, 4'b0000);
    chk("t2_dat1_hold", dat_o[15:8], 8'hA5);

    // 3: two channels hit the same write
    cfg(2'd2, 6'h3F, 6'h3F, 1'b1);
    bus("t3_cfg", 6'd0, 8'h00, 1'b0, 4'h0);
    bus("t3_overlap", 6'd63, 8'h3C, 1'b1, 4'b0101);
    chk("t3_cnt0", cnt_o[7:0],   8'd2);
    chk("t3_cnt2", cnt_o[23:16], 8'd1);
    chk("t3_dat2", dat_o[23:16], 8'h3C);

    // 4: saturation and clear priority
    for (int i = 0; i < 300; i++) bus("t4_burst", 6'd63, 8'(i), 1'b1, 4'b0101);
    chk("t4_sat0", cnt_o[7:0],   8'hFF);
    chk("t4_sat2", cnt_o[23:16], 8'hFF);
    clr_i = 4'b0001;
    bus("t4_clr_hit", 6'd63, 8'h77, 1'b1, 4'b0101);
    chk("t4_clrhit_cnt0", cnt_o[7:0], 8'd1);
    chk("t4_clrhit_flag", flag_o, 4'b0111);
    clr_i = 4'b0001;
    bus("t4_clr0", 6'd0, 8'h00, 1'b0, 4'h0);
    chk("t4_clr_cnt0", cnt_o[7:0], 8'd0);
    chk("t4_clr_flag", flag_o, 4'b0110);
    chk("t4_dat0_kept", dat_o[7:0], 8'h77);
    clr_i = 4'b1110;
    bus("t4_clr_rest", 6'd0, 8'h00, 1'b0, 4'h0);
    chk("t4_flags_off", flag_o, 4'h0);
    chk("t4_irq_lag", irq_o, 1'b1);
    bus("t4_idle", 6'd0, 8'h00, 1'b0, 4'h0);
    chk("t4_irq_off", irq_o, 1'b0);

    // 5: config write takes effect only from the next cycle
    cfg(2'd0, 6'd5, 6'h3F, 1'b1);
    bus("t5_old_cfg", 6'd63, 8'h01, 1'b1, 4'b0101);
    bus("t5_new_miss", 6'd63, 8'h02, 1'b1, 4'b0100);
    bus("t5_new_hit",  6'd5,  8'h03, 1'b1, 4'b0001);
    chk("t5_dat0", dat_o[7:0], 8'h03);
    cfg_sel_i = 2'd3; cfg_adr_i = '0; cfg_msk_i = '0; cfg_en_i = 1'b1; cfg_we3 = 1'b1;
    bus("t5_oor_cfg", 6'd0, 8'h00, 1'b0, 4'h0);
    bus("t5_adr0", 6'd0, 8'h04, 1'b1, 4'b0000);
    chk("t5_oor_nohit", detect3, 3'b000);
    bus("t5_adr63", 6'd63, 8'h05, 1'b1, 4'b0100);
    chk("t5_oor_ch0", detect3, 3'b001);

    // 6: asynchronous reset between edges
    bus("t6_pre", 6'd5, 8'hEE, 1'b1, 4'b0001);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("t6_detect", detect_o, 4'h0);
    chk("t6_flag",   flag_o,   4'h0);
    chk("t6_irq",    irq_o,    1'b0);
    chk("t6_cnt",    cnt_o,    32'h0);
    chk("t6_dat",    dat_o,    32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    bus("t6_dflt_hit",  6'd63, 8'h99, 1'b1, 4'b0001);
    bus("t6_dflt_miss", 6'd5,  8'h98, 1'b1, 4'b0000);
    chk("t6_cnt0", cnt_o, 32'h1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
